// File: rtl/axi_cdc_rd_pkg.sv
// AXI4 read-channel CDC: shared state encodings.
// Holds the s_clk and m_clk FSM state types.
package axi_cdc_rd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR_REQ,
    S_AR_REL,
    S_R_WAIT,
    S_R_HOLD,
    S_R_ACK
  } s_state_e;

  typedef enum logic [2:0] {
    M_IDLE,
    M_AR_ISS,
    M_R_WAIT,
    M_R_REQ,
    M_R_REL
  } m_state_e;

endpackage

// File: rtl/axi_cdc_rd_sync.sv
// Two-flop level synchroniser for one handshake flag.
// Ports: clk (destination clock), d (source flag), q (synced flag).
module axi_cdc_rd_sync (
  input  logic clk,
  input  logic d,
  output logic q
);

  // No reset: the source flag is reset, so the chain
  // flushes while both domains are held in reset.
  logic [1:0] sr;

  always_ff @(posedge clk)
    sr <= {sr[0], d};

  assign q = sr[1];

endmodule

// File: rtl/axi_cdc_rd.sv
// AXI4 read-channel CDC: AR s_clk->m_clk, R beats back.
// Ports: s_clk/s_rst + s_axi_ar*/r*, m_clk/m_rst + m_axi_ar*/r*.
module axi_cdc_rd
  import axi_cdc_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  m_clk,
  input  logic                  m_rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  s_state_e s_st;
  m_state_e m_st;

  logic s_req, s_rack;
  logic m_ack, m_rreq;
  logic s_req_m, s_rack_m;
  logic m_ack_s, m_rreq_s;

  // AR holding regs (s side), stable while s_req is high
  logic [ADDR_WIDTH-1:0] s_ar_addr;
  logic [ID_WIDTH-1:0]   s_ar_id;
  logic [7:0]            s_ar_len;
  logic [2:0]            s_ar_size;
  logic [1:0]            s_ar_burst;
  logic [2:0]            s_ar_prot;

  // R holding regs (m side), stable while m_rreq is high
  logic [DATA_WIDTH-1:0] m_r_data;
  logic [ID_WIDTH-1:0]   m_r_id;
  logic [1:0]            m_r_resp;
  logic                  m_r_last;

  axi_cdc_rd_sync u_sync_req (
    .clk (m_clk),
    .d   (s_req),
    .q   (s_req_m)
  );

  axi_cdc_rd_sync u_sync_rack (
    .clk (m_clk),
    .d   (s_rack),
    .q   (s_rack_m)
  );

  axi_cdc_rd_sync u_sync_ack (
    .clk (s_clk),
    .d   (m_ack),
    .q   (m_ack_s)
  );

  axi_cdc_rd_sync u_sync_rreq (
    .clk (s_clk),
    .d   (m_rreq),
    .q   (m_rreq_s)
  );

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      s_st          <= S_IDLE;
      s_req         <= 1'b0;
      s_rack        <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
    end else begin
      case (s_st)
        S_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            s_ar_addr     <= s_axi_araddr;
            s_ar_id       <= s_axi_arid;
            s_ar_len      <= s_axi_arlen;
            s_ar_size     <= s_axi_arsize;
            s_ar_burst    <= s_axi_arburst;
            s_ar_prot     <= s_axi_arprot;
            s_req         <= 1'b1;
            s_axi_arready <= 1'b0;
            s_st          <= S_AR_REQ;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        S_AR_REQ: begin
          if (m_ack_s) begin
            s_req <= 1'b0;
            s_st  <= S_AR_REL;
          end
        end
        S_AR_REL: begin
          if (!m_ack_s)
            s_st <= S_R_WAIT;
        end
        S_R_WAIT: begin
          if (m_rreq_s) begin
            s_axi_rdata  <= m_r_data;
            s_axi_rid    <= m_r_id;
            s_axi_rresp  <= m_r_resp;
            s_axi_rlast  <= m_r_last;
            s_axi_rvalid <= 1'b1;
            s_st         <= S_R_HOLD;
          end
        end
        S_R_HOLD: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_rack       <= 1'b1;
            s_st         <= S_R_ACK;
          end
        end
        S_R_ACK: begin
          if (!m_rreq_s) begin
            s_rack <= 1'b0;
            if (s_axi_rlast) begin
              s_axi_arready <= 1'b1;
              s_st          <= S_IDLE;
            end else begin
              s_st <= S_R_WAIT;
            end
          end
        end
        default: s_st <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      m_st          <= M_IDLE;
      m_ack         <= 1'b0;
      m_rreq        <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (s_req_m) begin
            m_axi_araddr  <= s_ar_addr;
            m_axi_arid    <= s_ar_id;
            m_axi_arlen   <= s_ar_len;
            m_axi_arsize  <= s_ar_size;
            m_axi_arburst <= s_ar_burst;
            m_axi_arprot  <= s_ar_prot;
            m_axi_arvalid <= 1'b1;
            m_ack         <= 1'b1;
            m_st          <= M_AR_ISS;
          end
        end
        M_AR_ISS: begin
          if (m_axi_arready)
            m_axi_arvalid <= 1'b0;
          // leave once AR is gone (or going) and s has released
          if ((!m_axi_arvalid || m_axi_arready) && !s_req_m) begin
            m_ack        <= 1'b0;
            m_axi_rready <= 1'b1;
            m_st         <= M_R_WAIT;
          end
        end
        M_R_WAIT: begin
          if (m_axi_rvalid) begin
            m_r_data     <= m_axi_rdata;
            m_r_id       <= m_axi_rid;
            m_r_resp     <= m_axi_rresp;
            m_r_last     <= m_axi_rlast;
            m_axi_rready <= 1'b0;
            m_rreq       <= 1'b1;
            m_st         <= M_R_REQ;
          end
        end
        M_R_REQ: begin
          if (s_rack_m) begin
            m_rreq <= 1'b0;
            m_st   <= M_R_REL;
          end
        end
        M_R_REL: begin
          if (!s_rack_m) begin
            if (m_r_last) begin
              m_st <= M_IDLE;
            end else begin
              m_axi_rready <= 1'b1;
              m_st         <= M_R_WAIT;
            end
          end
        end
        default: m_st <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_cdc_rd.sv
// Bench for axi_cdc_rd: random m-side responder,
// queue scoreboard, directed burst/backpressure/reset cases.
`timescale 1ns/1ps
module tb_axi_cdc_rd;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [2:0]  prot;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic s_clk, m_clk, s_rst, m_rst;
  logic [31:0] s_axi_araddr;
  logic [3:0]  s_axi_arid;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [3:0]  s_axi_rid;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arid;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [3:0]  m_axi_rid;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_cdc_rd dut (
    .s_clk(s_clk), .s_rst(s_rst), .m_clk(m_clk), .m_rst(m_rst),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  real s_half = 5.0;
  real m_half = 5.0;

  initial begin
    s_clk = 1'b0;
    forever #(s_half) s_clk = ~s_clk;
  end

  initial begin
    m_clk = 1'b0;
    forever #(m_half) m_clk = ~m_clk;
  end

  int total = 0;
  int bad = 0;

  ar_t         ar_q[$];
  beat_t       r_exp[$];
  beat_t       s_log[$];
  logic [31:0] mq_data[$];
  logic [1:0]  mq_resp[$];

  bit outstanding = 0;
  int exp_beats = 0;
  int beats_seen = 0;
  bit bp_en = 0;
  int bp_cnt = 0;
  int rr_pct = 70;
  int ar_pct = 50;
  int rv_pct = 50;
  logic [31:0] m_last_addr = '0;
  logic [3:0]  m_last_id = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // m-side slave model: random AR accept, arlen+1 beats
  initial begin : m_resp
    ar_t  a;
    beat_t b;
    bit   ar_hs, r_hs;
    int   left;
    logic [3:0] cid;
    logic [7:0] alen;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rid     = '0;
    m_axi_rresp   = '0;
    m_axi_rlast   = 1'b0;
    left = 0;
    cid  = '0;
    alen = '0;
    forever begin
      @(negedge m_clk);
      ar_hs = !m_rst && m_axi_arvalid && m_axi_arready;
      r_hs  = !m_rst && m_axi_rvalid && m_axi_rready;
      if (!m_rst && m_axi_rready)
        chk("m_rready_with_arvalid", m_axi_arvalid, 0);
      if (ar_hs) begin
        m_last_addr = m_axi_araddr;
        m_last_id   = m_axi_arid;
        alen        = m_axi_arlen;
        cid         = m_axi_arid;
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", ar_q.size(), 1);
        end else begin
          a = ar_q.pop_front();
          chk("m_ar", {m_axi_araddr, m_axi_arid, m_axi_arlen,
                       m_axi_arsize, m_axi_arburst,
                       m_axi_arprot}, a);
        end
      end
      if (r_hs) begin
        b.data = m_axi_rdata;
        b.id   = m_axi_rid;
        b.resp = m_axi_rresp;
        b.last = m_axi_rlast;
        r_exp.push_back(b);
      end
      @(posedge m_clk);
      #1;
      if (m_rst) begin
        left = 0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        continue;
      end
      if (ar_hs)
        left = int'(alen) + 1;
      if (r_hs) begin
        m_axi_rvalid = 1'b0;
        left--;
      end
      m_axi_arready = ($urandom_range(0, 99) < ar_pct);
      if (left > 0 && !m_axi_rvalid &&
          $urandom_range(0, 99) < rv_pct) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = (mq_data.size() > 0) ?
                       mq_data.pop_front() : $urandom;
        m_axi_rresp  = (mq_resp.size() > 0) ?
                       mq_resp.pop_front() :
                       2'($urandom_range(0, 3));
        m_axi_rid    = cid;
        m_axi_rlast  = (left == 1);
      end
    end
  end

  // s-side rready driver with optional hold on beat 2
  initial begin : s_rr
    s_axi_rready = 1'b0;
    forever begin
      @(posedge s_clk);
      #1;
      if (bp_en && beats_seen == 1 && bp_cnt < 20) begin
        s_axi_rready = 1'b0;
        if (s_axi_rvalid) begin
          bp_cnt++;
          chk("m_rready_in_bp", m_axi_rready, 0);
        end
      end else begin
        s_axi_rready = ($urandom_range(0, 99) < rr_pct);
      end
    end
  end

  // s-side compare process
  initial begin : s_mon
    beat_t e, got;
    bit    prev_pend;
    logic [38:0] prev_pl;
    prev_pend = 0;
    prev_pl   = '0;
    forever begin
      @(negedge s_clk);
      if (s_rst) begin
        prev_pend = 0;
        continue;
      end
      if (prev_pend)
        chk("r_stable", {s_axi_rvalid, s_axi_rdata, s_axi_rid,
                         s_axi_rresp}, prev_pl);
      if (outstanding)
        chk("arready_busy", s_axi_arready, 0);
      else
        chk("rvalid_idle", s_axi_rvalid, 0);
      if (s_axi_rvalid && s_axi_rready) begin
        if (r_exp.size() == 0) begin
          chk("r_extra", r_exp.size(), 1);
        end else begin
          e = r_exp.pop_front();
          chk("r_data", s_axi_rdata, e.data);
          chk("r_id", s_axi_rid, e.id);
          chk("r_resp", s_axi_rresp, e.resp);
          chk("r_last", s_axi_rlast, e.last);
        end
        got.data = s_axi_rdata;
        got.id   = s_axi_rid;
        got.resp = s_axi_rresp;
        got.last = s_axi_rlast;
        s_log.push_back(got);
        beats_seen++;
        if (s_axi_rlast) begin
          chk("beat_count", beats_seen, exp_beats);
          outstanding = 0;
        end
      end
      prev_pend = s_axi_rvalid && !s_axi_rready;
      prev_pl   = {s_axi_rvalid, s_axi_rdata, s_axi_rid,
                   s_axi_rresp};
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_read(input logic [31:0] addr,
                         input logic [3:0] id,
                         input logic [7:0] len,
                         input int abort_after);
    ar_t a;
    int  n;
    @(posedge s_clk);
    #1;
    s_axi_araddr  = addr;
    s_axi_arid    = id;
    s_axi_arlen   = len;
    s_axi_arsize  = 3'($urandom_range(0, 7));
    s_axi_arburst = 2'($urandom_range(0, 3));
    s_axi_arprot  = 3'($urandom_range(0, 7));
    s_axi_arvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge s_clk);
      if (s_axi_arready || n > 200)
        break;
      n++;
    end
    chk("ar_accept", s_axi_arready, 1);
    if (s_axi_arready) begin
      a = {addr, id, len, s_axi_arsize, s_axi_arburst,
           s_axi_arprot};
      ar_q.push_back(a);
    end
    @(posedge s_clk);
    #1;
    s_axi_arvalid = 1'b0;
    if (a.addr !== addr)
      return;
    s_log.delete();
    beats_seen  = 0;
    exp_beats   = int'(len) + 1;
    outstanding = 1;
    n = 0;
    while (outstanding &&
           !(abort_after > 0 && beats_seen >= abort_after) &&
           n < 4000) begin
      @(negedge s_clk);
      n++;
    end
    if (abort_after > 0)
      return;
    chk("burst_done", outstanding, 0);
    n = 0;
    while (!s_axi_arready && n < 20) begin
      @(negedge s_clk);
      n++;
    end
    chk("arready_back", s_axi_arready, 1);
  endtask

  task automatic log_chk(input string nm, input int i,
                         input logic [31:0] d,
                         input logic [1:0] rs, input logic l);
    if (i >= s_log.size()) begin
      chk({nm, "_missing"}, s_log.size(), i + 1);
    end else begin
      chk({nm, "_data"}, s_log[i].data, d);
      chk({nm, "_resp"}, s_log[i].resp, rs);
      chk({nm, "_last"}, s_log[i].last, l);
    end
  endtask

  task automatic rst_assert();
    @(posedge s_clk);
    #1;
    s_rst = 1'b1;
    @(posedge m_clk);
    #1;
    m_rst = 1'b1;
    repeat (12) @(posedge s_clk);
    repeat (12) @(posedge m_clk);
    ar_q.delete();
    r_exp.delete();
    mq_data.delete();
    mq_resp.delete();
    outstanding = 0;
    beats_seen  = 0;
    @(negedge s_clk);
    chk("rst_s_rvalid", s_axi_rvalid, 0);
    @(negedge m_clk);
    chk("rst_m_arvalid", m_axi_arvalid, 0);
    chk("rst_m_rready", m_axi_rready, 0);
  endtask

  task automatic rst_release();
    @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    @(posedge m_clk);
    #1;
    m_rst = 1'b0;
    repeat (3) @(negedge s_clk);
    chk("rst_arready", s_axi_arready, 1);
    chk("rst_rvalid_after", s_axi_rvalid, 0);
  endtask

  initial begin : main
    real sh[3];
    real mh[3];
    s_rst = 1'b1;
    m_rst = 1'b1;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arid    = '0;
    s_axi_arlen   = '0;
    s_axi_arsize  = '0;
    s_axi_arburst = '0;
    s_axi_arprot  = '0;
    sh[0] = 5.0;  mh[0] = 5.0;
    sh[1] = 5.0;  mh[1] = 18.5;
    sh[2] = 20.5; mh[2] = 5.0;

    rst_assert();
    rst_release();

    mq_data.push_back(32'hDEADBEEF);
    mq_resp.push_back(2'd0);
    do_read(32'h1000, 4'd3, 8'd0, 0);
    chk("single_m_addr", m_last_addr, 32'h1000);
    chk("single_m_id", m_last_id, 4'd3);
    log_chk("single", 0, 32'hDEADBEEF, 2'd0, 1'b1);
    chk("single_n", s_log.size(), 1);

    for (int i = 0; i < 4; i++) begin
      mq_data.push_back(32'h11 * (i + 1));
      mq_resp.push_back(2'd0);
    end
    do_read(32'h4000, 4'd7, 8'd3, 0);
    chk("burst_n", s_log.size(), 4);
    log_chk("burst0", 0, 32'h11, 2'd0, 1'b0);
    log_chk("burst1", 1, 32'h22, 2'd0, 1'b0);
    log_chk("burst2", 2, 32'h33, 2'd0, 1'b0);
    log_chk("burst3", 3, 32'h44, 2'd0, 1'b1);

    rr_pct = 100;
    bp_cnt = 0;
    bp_en  = 1;
    do_read(32'h5000, 4'd1, 8'd3, 0);
    bp_en  = 0;
    rr_pct = 70;
    chk("bp_cycles", bp_cnt, 20);
    chk("bp_n", s_log.size(), 4);

    mq_data.push_back(32'hA5A50001);
    mq_data.push_back(32'hA5A50002);
    mq_resp.push_back(2'd2);
    mq_resp.push_back(2'd0);
    do_read(32'h6000, 4'd2, 8'd1, 0);
    log_chk("slverr0", 0, 32'hA5A50001, 2'd2, 1'b0);
    log_chk("slverr1", 1, 32'hA5A50002, 2'd0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      s_half = sh[r];
      m_half = mh[r];
      repeat (4) @(posedge s_clk);
      for (int k = 0; k < 6; k++)
        do_read($urandom, 4'($urandom_range(0, 15)),
                8'($urandom_range(0, 7)), 0);
    end

    do_read(32'h3000, 4'd5, 8'd3, 1);
    rst_assert();
    rst_release();
    do_read(32'h2000, 4'd9, 8'd2, 0);
    chk("post_rst_addr", m_last_addr, 32'h2000);
    chk("post_rst_id", m_last_id, 4'd9);
    chk("post_rst_n", s_log.size(), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
